// File: rtl/result_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : result_sched_pkg                                         |
// | Description : Shared state encodings and detection type for the        |
// |               result scheduler.                                         |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
package result_sched_pkg;

    localparam int c_WIDTH_POSI = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b11,
        S_FLUSH = 2'b10
    } state_t;

    typedef struct packed {
        logic [c_WIDTH_POSI-1:0] xpos;
        logic [c_WIDTH_POSI-1:0] ypos;
        logic [c_WIDTH_POSI-1:0] length;
    } det_t;

endpackage
`default_nettype wire

// File: rtl/result_sched_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : result_sched_if                                          |
// | Description : FDE-side and writer-side signals of the result scheduler. |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
interface result_sched_if #(
    parameter int WIDTH_POSI = 8,
    parameter int WIDTH_CNT  = 4
);
    logic                  det_valid;
    logic [WIDTH_POSI-1:0] det_xpos;
    logic [WIDTH_POSI-1:0] det_ypos;
    logic [WIDTH_POSI-1:0] det_length;
    logic                  det_ready;
    logic                  frame_end;
    logic                  wr_start;
    logic [WIDTH_POSI-1:0] wr_xpos;
    logic [WIDTH_POSI-1:0] wr_ypos;
    logic [WIDTH_POSI-1:0] wr_length;
    logic                  wr_done;
    logic                  frame_done;
    logic [WIDTH_CNT-1:0]  count;

    modport master (
        output det_valid, det_xpos, det_ypos, det_length, frame_end, wr_done,
        input  det_ready, wr_start, wr_xpos, wr_ypos, wr_length, frame_done, count
    );

    modport slave (
        input  det_valid, det_xpos, det_ypos, det_length, frame_end, wr_done,
        output det_ready, wr_start, wr_xpos, wr_ypos, wr_length, frame_done, count
    );
endinterface
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : result_fifo                                              |
// | Description : DEPTH-entry synchronous FIFO of packed detections.        |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module result_fifo
    import result_sched_pkg::*;
#(
    parameter int  DEPTH     = 8,
    parameter int  WIDTH_CNT = 4,
    parameter type T         = det_t
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 push,
    input  wire logic                 pop,
    input  wire T                     din,
    output T                          dout,
    output logic                      full,
    output logic                      empty,
    output logic [WIDTH_CNT-1:0]      count
);
    localparam int c_PTR_W = $clog2(DEPTH);

    T                     r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [WIDTH_CNT-1:0] r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign full      = (r_count == WIDTH_CNT'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + WIDTH_CNT'(1);
                2'b01:   r_count <= r_count - WIDTH_CNT'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/result_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : result_sched                                             |
// | Description : Queues FDE detections and issues them one at a time to    |
// |               the result writer; flags end of frame once drained.      |
// |               Optional duplicate filter: RESULT_SCHED_DUP_FILTER_EN.    |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module result_sched
    import result_sched_pkg::*;
#(
    parameter int WIDTH_POSI = c_WIDTH_POSI,
    parameter int DEPTH      = 8,
    parameter int WIDTH_CNT  = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    result_sched_if.slave bus
);
    typedef struct packed {
        logic [WIDTH_POSI-1:0] xpos;
        logic [WIDTH_POSI-1:0] ypos;
        logic [WIDTH_POSI-1:0] length;
    } entry_t;

    entry_t               w_din;
    entry_t               w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push_acc;
    logic                 w_push;
    logic                 w_pop;
    logic [WIDTH_CNT-1:0] w_count;

    state_t               r_state;
    logic                 r_pending;
    logic                 r_wr_start;
    logic                 r_frame_done;
    entry_t               r_wr;

    assign w_din      = {bus.det_xpos, bus.det_ypos, bus.det_length};
    assign w_push_acc = bus.det_valid && !w_full;
    assign w_pop      = (r_state == S_IDLE) && !w_empty;

`ifdef RESULT_SCHED_DUP_FILTER_EN
    entry_t r_last;
    logic   r_last_vld;
    logic   w_dup;

    // A repeat of the last accepted detection is consumed but not queued.
    assign w_dup  = r_last_vld && (r_last == w_din);
    assign w_push = w_push_acc && !w_dup;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else if (w_push_acc) begin
            r_last     <= w_din;
            r_last_vld <= 1'b1;
        end else if (r_state == S_FLUSH) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end
    end
`else
    assign w_push = w_push_acc;
`endif

    result_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH_CNT (WIDTH_CNT),
        .T         (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Strobes are set on the transition into their state so they are flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pending    <= 1'b0;
            r_wr_start   <= 1'b0;
            r_frame_done <= 1'b0;
            r_wr         <= '0;
        end else begin
            r_wr_start   <= 1'b0;
            r_frame_done <= 1'b0;
            if (bus.frame_end) r_pending <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_wr       <= w_head;
                        r_wr_start <= 1'b1;
                        r_state    <= S_ISSUE;
                    end else if (r_pending) begin
                        r_wr         <= '0;
                        r_frame_done <= 1'b1;
                        r_state      <= S_FLUSH;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (bus.wr_done) r_state <= S_IDLE;
                end
                S_FLUSH: begin
                    // A marker landing here is absorbed into the frame being closed.
                    r_pending <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.det_ready  = !w_full;
    assign bus.wr_start   = r_wr_start;
    assign bus.wr_xpos    = r_wr.xpos;
    assign bus.wr_ypos    = r_wr.ypos;
    assign bus.wr_length  = r_wr.length;
    assign bus.frame_done = r_frame_done;
    assign bus.count      = w_count;

endmodule
`default_nettype wire
